// File: rtl/exec_core.sv
// exec_core: multi-cycle fetch/decode/execute core with req/ack memory and AU links; define EXEU_BRANCH_EN to enable JMP/BNZ
module exec_core #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc_init,
  output logic              busy,
  output logic              halted,
  output logic              err,
  output logic              retire,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              au_req,
  output logic [3:0]        au_mode,
  output logic [DATA_W-1:0] au_a,
  output logic [DATA_W-1:0] au_b,
  input  logic [DATA_W-1:0] au_result,
  input  logic              au_ack,
  input  logic [REG_AW-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, IMM, MEM, AU, HALT} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, iaddr;
  logic [DATA_W-1:0] ir, opnd, rf_wdata;
  logic [DATA_W-1:0] regs [2**REG_AW];
  logic [3:0] op;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic rf_we, done, set_err, illegal, br_take;
  assign op = ir[DATA_W-1 -: 4];
  assign rd = ir[DATA_W-5 -: REG_AW];
  assign rs1 = ir[DATA_W-5-REG_AW -: REG_AW];
  assign rs2 = ir[DATA_W-5-2*REG_AW -: REG_AW];
  assign iaddr = ir[ADDR_W-1:0];
`ifdef EXEU_BRANCH_EN
  assign illegal = 1'b0;
  assign br_take = op == 4'b0100 || (op == 4'b0101 && regs[rd] != '0);
`else
  assign illegal = op[3:1] == 3'b010;
  assign br_take = 1'b0;
`endif
  always_comb begin
    state_n = state;
    pc_n = pc;
    rf_we = 1'b0;
    rf_wdata = mem_rdata;
    done = 1'b0;
    set_err = 1'b0;
    case (state)
      IDLE, HALT: begin
        state_n = start ? FETCH : state;
        pc_n = start ? pc_init : pc;
      end
      FETCH: begin
        state_n = mem_ack ? DECODE : FETCH;
        pc_n = mem_ack ? pc + 1'b1 : pc;
      end
      DECODE: begin
        set_err = illegal;
        state_n = (illegal || op == 4'b0111) ? HALT : op[3] ? (op[0] ? IMM : AU) :
                  !op[2] ? (op[0] ? IMM : MEM) : FETCH;
        done = !illegal && op[3:2] == 2'b01 && op[1:0] != 2'b11;
        pc_n = br_take ? iaddr : pc;
      end
      IMM: begin
        state_n = !mem_ack ? IMM : op == 4'b0001 ? FETCH : op[3] ? AU : MEM;
        pc_n = mem_ack ? pc + 1'b1 : pc;
        rf_we = mem_ack && op == 4'b0001;
        done = rf_we;
      end
      MEM: begin
        state_n = mem_ack ? FETCH : MEM;
        done = mem_ack;
        rf_we = mem_ack && op == 4'b0000;
      end
      AU: begin
        state_n = au_ack ? FETCH : AU;
        done = au_ack;
        rf_we = au_ack;
        rf_wdata = au_result;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= '0;
      ir <= '0;
      opnd <= '0;
      err <= 1'b0;
      retire <= 1'b0;
      for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      retire <= done;
      err <= set_err | (err & ~(start & ~busy));
      if (state == FETCH && mem_ack) ir <= mem_rdata;
      if (state == IMM && mem_ack) opnd <= mem_rdata;
      if (rf_we) regs[rd] <= rf_wdata;
    end
  end
  assign busy = state != IDLE && state != HALT;
  assign halted = state == HALT;
  assign mem_req = state == FETCH || state == IMM || state == MEM;
  assign mem_we = state == MEM && op[1];
  assign mem_addr = state == MEM ? iaddr : mem_req ? pc : '0;
  assign mem_wdata = mem_we ? (op[0] ? opnd : regs[rd]) : '0;
  assign au_req = state == AU;
  assign au_mode = au_req ? {op[3:1], 1'b0} : 4'h0;
  assign au_a = au_req ? regs[rs1] : '0;
  assign au_b = au_req ? (op[0] ? opnd : regs[rs2]) : '0;
  assign dbg_rdata = regs[dbg_raddr];
endmodule

// File: doc/exec_core.md
# exec_core

Parametrised, clocked successor of the co-processor execution unit. A multi-cycle fetch/decode/execute state machine reads instructions from the memory unit and dispatches arithmetic work to the AU. Both links use req/ack handshakes. The block owns the program counter and a parametrised register bank, and adds run/halt control, illegal-opcode detection, a retire strobe, a debug register read port and optional branches.

## Interface
- DATA_W, 16: instruction, register and data width.
- REG_AW, 3: register address width; NREGS = 2**REG_AW.
- ADDR_W, 8: memory address width; must satisfy ADDR_W <= DATA_W-4-REG_AW.
- clk  in  1  Clock.
- rst_n  in  1  Reset: one clock; synchronous, active-low.
- start  in  1  Pulse; in IDLE/HALT loads PC from pc_init and begins execution. Ignored while busy.
- pc_init  in  ADDR_W  Start address.
- busy  out  1  High in every state except IDLE/HALT.
- halted  out  1  High in HALT.
- err  out  1  Sticky illegal-opcode flag.
- retire  out  1  One-cycle pulse per completed instruction.
- mem_req, mem_we  out  1  Memory request and write enable.
- mem_addr  out  ADDR_W  Memory address.
- mem_wdata  out  DATA_W  Memory write data.
- mem_rdata  in  DATA_W  Memory read data.
- mem_ack  in  1  Memory acknowledge.
- au_req  out  1  AU request.
- au_mode  out  4  AU mode.
- au_a, au_b  out  DATA_W  AU operands.
- au_result  in  DATA_W  AU result.
- au_ack  in  1  AU acknowledge.
- dbg_raddr  in  REG_AW  Debug register select.
- dbg_rdata  out  DATA_W  Combinational read of reg[dbg_raddr].

## Operation
- Instruction fields: op = [DATA_W-1 -: 4]; rd = next REG_AW bits; rs1 = next REG_AW bits; rs2 = next REG_AW bits; addr = [ADDR_W-1:0].
- Opcodes:
  - 0000 LD: rd <= mem[addr].
  - 0001 LDI: rd <= next word.
  - 0010 ST: mem[addr] <= rd.
  - 0011 STI: mem[addr] <= next word.
  - 0100 JMP: PC <= addr.
  - 0101 BNZ: if rd != 0, PC <= addr.
  - 0110 NOP.
  - 0111 HALT.
  - 1xx0: rd <= AU(mode = op, rs1, rs2).
  - 1xx1: rd <= AU(mode = {op[3:1], 0}, rs1, next word).
- The next word is fetched from PC+1; PC then advances past it.
- States and transitions:
  - IDLE: on start -> FETCH.
  - FETCH: req at PC; IR <= rdata on ack -> DECODE.
  - DECODE: -> IMM (immediate forms), MEM (LD/ST), AU (1xx0), or resolves JMP/BNZ/NOP/HALT in place.
  - IMM: fetch PC+1 into an operand latch -> MEM (STI), AU (1xx1), or writeback (LDI).
  - MEM: single read or write transfer.
  - AU: single AU transfer; result is written back on ack.
  - After completion: -> FETCH with the updated PC, or -> HALT.
- PC arithmetic is modulo 2**ADDR_W; address 0xFF + 1 wraps to 0x00.
- Illegal opcode: err <= 1, retire stays low, go to HALT.
- Register 0 is an ordinary writable register.
- Register writes land on the edge of the completing ack; dbg_rdata reflects the write in the following cycle.

## Timing
- Handshakes: req, we, addr, wdata and operands are held stable until the edge where req && ack, and req drops on that edge. An ack sampled while req is low is ignored. An ack may be combinational, in the same cycle req is high.
- Zero-wait instruction latency:
  - NOP, JMP, BNZ: 2 cycles.
  - LD, ST, 1xx0 AU: 3 cycles.
  - LDI: 3 cycles.
  - STI, 1xx1 AU: 4 cycles.
  - Each wait cycle adds 1.
- retire pulses in the cycle after the completing edge.
- Reset values: all outputs 0; PC 0; all registers 0; state IDLE.
- Reset mid-transfer aborts the transfer: req is low in the cycle after the reset edge, and no register or PC update occurs.
- start pulsed in HALT clears err, reloads PC and enters FETCH on the next edge.

## Configuration
- EXEU_BRANCH_EN defined: JMP and BNZ execute as specified above.
- EXEU_BRANCH_EN undefined: opcodes 0100 and 0101 are illegal (err=1, HALT) and no branch logic is synthesised.

## Test plan
- LDI r1,#0x1234 at 0x00/0x01, then HALT, zero-wait memory -> reg1=0x1234; retire count 1; halted=1 after 5 cycles from start.
- LD r2,[0x20] with mem[0x20]=0xBEEF, memory ack delayed 3 cycles -> mem_addr stable at 0x20 throughout the wait, reg2=0xBEEF, LD latency 6 cycles.
- r1=5, r2=7; 1000 r3,r1,r2 -> au_mode=0x8, au_a=5, au_b=7; au_result=12 -> reg3=0x000C.
- STI [0x30],#0xA5A5 -> write transfer with mem_we=1, mem_addr=0x30, mem_wdata=0xA5A5; PC skips the immediate.
- With branches enabled: r1=1; BNZ r1,0x10 -> next fetch at 0x10. With branches disabled: the same BNZ sets err=1 and halted=1.
- Reset asserted while mem_req is high -> mem_req=0, busy=0 and all registers 0 in the cycle after the reset edge; a subsequent start fetches from pc_init.
